// File: rtl/checkpoint_sequence_monitor.sv
// Checkpoint-bus monitor: checks start/end marker order per (round, test), applies a global timeout
// and records per-test latency. Markers take effect SYNC_STAGES+1 cycles after the bus changes; no backpressure.
module checkpoint_sequence_monitor #(
  parameter int         NUM_TESTS      = 3,
  parameter int         NUM_ROUNDS     = 3,
  parameter logic [7:0] MARKER         = 8'hAB,
  parameter int         CNT_W          = 24,
  parameter int         TIMEOUT_CYCLES = 150000,
  parameter int         SYNC_STAGES    = 2,
  localparam int        NUM_ENT        = NUM_ROUNDS * NUM_TESTS,
  localparam int        SEL_W          = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1,
  localparam int        RND_W          = $clog2(NUM_ROUNDS) + 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [15:0]      checkbits,
  input  logic [SEL_W-1:0] lat_sel,
  output logic [CNT_W-1:0] lat_out,
  output logic [3:0]       cur_test,
  output logic [RND_W-1:0] cur_round,
  output logic             running,
  output logic             done,
  output logic             fail,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] total_cycles
);

  typedef enum logic [1:0] {S_WAIT_START, S_RUNNING, S_DONE, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_TEST  = 4'(NUM_TESTS - 1);
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);
  localparam logic [SEL_W:0]   NUM_ENT_W  = (SEL_W + 1)'(NUM_ENT);

  state_t           r_state;
  logic [15:0]      r_sync [SYNC_STAGES];
  logic [15:0]      r_prev;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_lat_tbl [NUM_ENT];
  logic [3:0]       r_cur_test;
  logic [RND_W-1:0] r_cur_round;
  logic             r_running;
  logic             r_done;
  logic             r_fail;
  logic [1:0]       r_err_code;

  logic [15:0]      w_sync_q;
  logic [15:0]      w_expected;
  logic             w_active;
  logic             w_evt;
  logic             w_evt_ok;
  logic             w_evt_bad;
  logic             w_final;
  logic             w_total_inc;
  logic             w_timeout;
  logic [CNT_W-1:0] w_lat_next;
  logic [SEL_W-1:0] w_wr_idx;

  assign w_sync_q    = r_sync[SYNC_STAGES-1];
  assign w_active    = (r_state == S_WAIT_START) || (r_state == S_RUNNING);
  assign w_expected  = {MARKER, r_cur_test, 3'b000, (r_state == S_RUNNING)};
  assign w_evt       = (w_sync_q != r_prev) && (w_sync_q[15:8] == MARKER);
  assign w_evt_ok    = w_active && w_evt && (w_sync_q == w_expected);
  assign w_evt_bad   = w_active && w_evt && (w_sync_q != w_expected);
  assign w_final     = w_evt_ok && (r_state == S_RUNNING) && (r_cur_test == LAST_TEST) &&
                       (r_cur_round == LAST_ROUND);
  assign w_total_inc = w_active && (r_total != CNT_MAX);
  assign w_timeout   = w_total_inc && (r_total == TO_LAST);
  // Written value is the count the cycle would reach, so latency equals the start-to-end event distance.
  assign w_lat_next  = (r_lat_cnt == CNT_MAX) ? r_lat_cnt : r_lat_cnt + 1'b1;
  assign w_wr_idx    = SEL_W'(r_cur_round * NUM_TESTS + r_cur_test);

  always_comb begin
    lat_out = '0;
    if ({1'b0, lat_sel} < NUM_ENT_W) lat_out = r_lat_tbl[lat_sel];
  end

  assign cur_test     = r_cur_test;
  assign cur_round    = r_cur_round;
  assign running      = r_running;
  assign done         = r_done;
  assign fail         = r_fail;
  assign err_code     = r_err_code;
  assign total_cycles = r_total;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= checkbits;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_WAIT_START;
      r_lat_cnt   <= '0;
      r_total     <= '0;
      r_cur_test  <= '0;
      r_cur_round <= '0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_err_code  <= 2'd0;
      for (int i = 0; i < NUM_ENT; i++) r_lat_tbl[i] <= '0;
    end else begin
      // The global counter freezes at TIMEOUT_CYCLES-1 on the cycle the timeout is judged.
      if (w_total_inc && !w_timeout) r_total <= r_total + 1'b1;
      case (r_state)
        S_WAIT_START, S_RUNNING: begin
          if (r_state == S_RUNNING) r_lat_cnt <= w_lat_next;
          if (w_evt_bad) begin
            r_state    <= S_FAIL;
            r_fail     <= 1'b1;
            r_err_code <= 2'd1;
            r_running  <= 1'b0;
          end else if (w_final) begin
            r_lat_tbl[w_wr_idx] <= w_lat_next;
            r_running   <= 1'b0;
            r_cur_test  <= '0;
            r_cur_round <= r_cur_round + 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_state    <= S_FAIL;
            r_fail     <= 1'b1;
            r_err_code <= 2'd2;
            r_running  <= 1'b0;
          end else if (w_evt_ok) begin
            if (r_state == S_WAIT_START) begin
              r_state   <= S_RUNNING;
              r_running <= 1'b1;
              r_lat_cnt <= '0;
            end else begin
              r_lat_tbl[w_wr_idx] <= w_lat_next;
              r_running <= 1'b0;
              r_state   <= S_WAIT_START;
              if (r_cur_test == LAST_TEST) begin
                r_cur_test  <= '0;
                r_cur_round <= r_cur_round + 1'b1;
              end else begin
                r_cur_test <= r_cur_test + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checkpoint_sequence_monitor.sv
// Bench for checkpoint_sequence_monitor: vector table, directed corner sequences and randomized
// episodes checked against a marker-position model.
module tb_checkpoint_sequence_monitor;

  localparam int NT    = 3;
  localparam int NR    = 3;
  localparam int S     = 2;
  localparam int TO    = 1000;
  localparam int CW    = 24;
  localparam int NE    = NT * NR;
  localparam int NFULL = 2 * NT * NR;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cb;
  logic [3:0]    sel;
  logic [CW-1:0] lat_out;
  logic [CW-1:0] total;
  logic [3:0]    cur_test;
  logic [2:0]    cur_round;
  logic          running;
  logic          done;
  logic          fail;
  logic [1:0]    err;

  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  checkpoint_sequence_monitor #(
    .NUM_TESTS(NT), .NUM_ROUNDS(NR), .MARKER(8'hAB), .CNT_W(CW),
    .TIMEOUT_CYCLES(TO), .SYNC_STAGES(S)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .checkbits(cb), .lat_sel(sel), .lat_out(lat_out),
    .cur_test(cur_test), .cur_round(cur_round), .running(running), .done(done),
    .fail(fail), .err_code(err), .total_cycles(total)
  );

  typedef struct {
    int          rst_first;
    logic [15:0] val;
    int          hold;
    int          e_run;
    int          e_test;
    int          e_round;
    int          e_done;
    int          e_fail;
    int          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] marker(input int p);
    logic [3:0] t;
    t = 4'((p / 2) % NT);
    return {8'hAB, t, 3'b000, 1'(p % 2)};
  endfunction

  function automatic vec_t full_vec(input int p);
    vec_t v;
    int   q;
    q = p + 1;
    v = '{(p == 0), marker(p), 50, q % 2, (q / 2) % NT, q / (2 * NT), (q == NFULL), 0, 0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int r, input int t, input int rd,
                            input int dn, input int fl, input int ec);
    check({tag, ".running"},   32'(running),   r);
    check({tag, ".cur_test"},  32'(cur_test),  t);
    check({tag, ".cur_round"}, 32'(cur_round), rd);
    check({tag, ".done"},      32'(done),      dn);
    check({tag, ".fail"},      32'(fail),      fl);
    check({tag, ".err_code"},  32'(err),       ec);
  endtask

  task automatic check_lats(input string tag, input int exp);
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i);
      #1;
      check($sformatf("%s.lat%0d", tag, i), 32'(lat_out), (i < NE) ? exp : 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cb  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [15:0] v, input int hold);
    cb = v;
    repeat (hold) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_seq(input int n, input int gap);
    for (int p = 0; p < n; p++) drive(marker(p), gap);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          p, steps, gap, r, d, start_d, term_total;
    int          m_active, m_done, m_fail;
    int          exp_tbl [NE];
    logic [15:0] val, last_val;

    for (int i = 0; i < NFULL; i++) vecs.push_back(full_vec(i));
    vecs.push_back('{1, 16'hAB00, 10, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 16'hAB11, 10, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 16'hAB01, 10, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 16'hAB10, 10, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 16'h0000, 10, 0, 0, 0, 0, 1, 1});

    // Reset state while reset is held
    rst = 1'b1; cb = 16'h0000; sel = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    check("reset.total", 32'(total), 0);
    check_lats("reset", 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first != 0) do_reset();
      drive(vecs[i].val, vecs[i].hold);
      check_outs($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_test, vecs[i].e_round,
                 vecs[i].e_done, vecs[i].e_fail, vecs[i].e_err);
      if (i == NFULL - 1) begin
        check("full.total", 32'(total), (NFULL - 1) * 50 + S + 1);
        check_lats("full", 50);
      end
    end

    // Out-of-order end marker lands exactly SYNC_STAGES+1 cycles after the change
    do_reset();
    drive(16'hAB00, 10);
    cb = 16'hAB11;
    repeat (S) @(posedge clk);
    @(negedge clk);
    check("ooo.early_fail", 32'(fail), 0);
    @(posedge clk);
    @(negedge clk);
    check_outs("ooo", 0, 0, 0, 0, 1, 1);

    // Held marker gives no repeat event; a marker re-appearing after a non-marker does
    do_reset();
    drive(16'hAB00, 10);
    drive(16'hAB00, 20);
    check_outs("hold", 1, 0, 0, 0, 0, 0);
    drive(16'h1234, 10);
    check_outs("nonmarker", 1, 0, 0, 0, 0, 0);
    drive(16'hAB00, 10);
    check_outs("stale", 0, 0, 0, 0, 1, 1);

    // Global timeout with an idle bus
    do_reset();
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    check("to.before_fail", 32'(fail), 0);
    check("to.before_total", 32'(total), TO - 1);
    @(posedge clk);
    @(negedge clk);
    check_outs("to", 0, 0, 0, 0, 1, 2);
    check("to.total", 32'(total), TO - 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("to.total_hold", 32'(total), TO - 1);

    // Reset while running test 1 of round 2 abandons everything
    do_reset();
    run_seq(15, 10);
    check_outs("mid", 1, 1, 2, 0, 0, 0);
    rst = 1'b1; cb = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outs("midrst", 0, 0, 0, 0, 0, 0);
    check("midrst.total", 32'(total), 0);
    check_lats("midrst", 0);
    run_seq(NFULL, 10);
    check_outs("after_rst", 0, 0, NR, 1, 0, 0);
    check_lats("after_rst", 10);

    // Final end marker on the timeout cycle completes the run
    do_reset();
    run_seq(NFULL - 1, 10);
    wait_cyc(TO - 1 - S);
    drive(marker(NFULL - 1), S + 1);
    check_outs("final_on_to", 0, 0, NR, 1, 0, 0);

    // Non-final expected marker on the timeout cycle loses to the timeout
    do_reset();
    wait_cyc(TO - 1 - S);
    drive(16'hAB00, S + 1);
    check_outs("start_on_to", 0, 0, 0, 0, 1, 2);

    // Out-of-order marker on the timeout cycle wins over the timeout
    do_reset();
    wait_cyc(TO - 1 - S);
    drive(16'hAB01, S + 1);
    check_outs("ooo_on_to", 0, 0, 0, 0, 1, 1);

    // Randomized episodes against the marker-position model
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      p = 0; m_active = 1; m_done = 0; m_fail = 0; last_val = 16'h0000;
      start_d = 0; term_total = 0;
      for (int i = 0; i < NE; i++) exp_tbl[i] = 0;
      steps = $urandom_range(10, 40);
      for (int s = 0; s < steps; s++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      val = marker(p);
        else if (r < 80) val = last_val;
        else if (r < 92) begin
          val = 16'($urandom_range(0, 65535));
          if (val[15:8] == 8'hAB) val[15:8] = 8'h12;
        end else         val = {8'hAB, 8'($urandom_range(0, 255))};
        gap = $urandom_range(S + 1, 12);
        d = cyc;
        drive(val, gap);
        if (m_active != 0 && val != last_val && val[15:8] == 8'hAB) begin
          if (val == marker(p)) begin
            if (p % 2 == 0) start_d = d;
            else            exp_tbl[p / 2] = d - start_d;
            p++;
            if (p == NFULL) begin
              m_active = 0; m_done = 1; term_total = d + S + 1;
            end
          end else begin
            m_active = 0; m_fail = 1; term_total = d + S + 1;
          end
        end
        last_val = val;
        check_outs($sformatf("rnd%0d.%0d", ep, s), m_active & (p % 2), (p / 2) % NT,
                   p / (2 * NT), m_done, m_fail, m_fail);
        check($sformatf("rnd%0d.%0d.total", ep, s), 32'(total),
              (m_active != 0) ? cyc : term_total);
      end
      for (int i = 0; i < 16; i++) begin
        sel = 4'(i);
        #1;
        check($sformatf("rnd%0d.lat%0d", ep, i), 32'(lat_out), (i < NE) ? exp_tbl[i] : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/checkpoint_sequence_monitor.md
Name: checkpoint_sequence_monitor

Overview:
- Synthesisable monitor for the 16-bit firmware checkpoint bus (mprj_io[31:16] in the harness).
- Decodes start/end markers for a parametrised number of workloads (FIR, matmul, qsort, …) over a parametrised number of rounds.
- Enforces ordering, applies a global cycle timeout, and records per-(round, test) latency in cycles.
- Sits beside the user project, so benches and on-chip logic-analyser probes share one pass/fail verdict.

Parameters:
- NUM_TESTS, 3, workloads per round; test id occupies marker bits [7:4], so max 16.
- NUM_ROUNDS, 3, rounds expected before DONE.
- MARKER, 8'hAB, required value of marker bits [15:8].
- CNT_W, 24, width of latency and global counters; both saturate at all-ones.
- TIMEOUT_CYCLES, 150000, global cycle budget counted from reset release.
- SYNC_STAGES, 2, input synchroniser depth; must be ≥1.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- checkbits  in  16  checkpoint bus, asynchronous to wb_clk_i.
- lat_sel  in  $clog2(NUM_ROUNDS*NUM_TESTS)  latency table index = round*NUM_TESTS + test.
- lat_out  out  CNT_W  latency table entry at lat_sel; combinational read.
- cur_test  out  4  expected test id.
- cur_round  out  $clog2(NUM_ROUNDS)+1  expected round.
- running  out  1  high between an accepted start and its end.
- done  out  1  all rounds completed without error; sticky.
- fail  out  1  error occurred; sticky.
- err_code  out  2  0 none, 1 out-of-order marker, 2 timeout, 3 reserved.
- total_cycles  out  CNT_W  global cycle counter.

Behaviour:
- Reset (wb_rst_i=1 at posedge): clear every synchroniser stage, the prev register, all counters and the latency table to 0. running=done=fail=0, err_code=0, cur_test=0, cur_round=0, state=WAIT_START. Reset mid-run abandons all progress.
- Input path: checkbits passes through SYNC_STAGES flops to give sync_q; prev holds sync_q delayed one cycle.
- Event: a one-cycle pulse when sync_q != prev and sync_q[15:8] == MARKER. Non-marker values and unchanged values produce no event.
- Event latency: SYNC_STAGES+1 cycles after checkbits changes.
- Expected marker: {MARKER, cur_test, 4'h0} in WAIT_START; {MARKER, cur_test, 4'h1} in RUNNING.
- WAIT_START, expected event: go to RUNNING, set running=1, clear lat_cnt to 0.
- RUNNING: lat_cnt increments each cycle, saturating.
- RUNNING, expected end event: write lat_cnt into table[cur_round*NUM_TESTS+cur_test], set running=0.
  - Latency therefore equals the cycle distance between the start and end events.
  - If cur_test < NUM_TESTS-1: cur_test+1, go to WAIT_START.
  - Else: cur_test=0, cur_round+1. If cur_round now equals NUM_ROUNDS, go to DONE, set done=1. Otherwise go to WAIT_START.
- Any marker event not equal to the expected marker, in WAIT_START or RUNNING: go to FAIL, set fail=1, err_code=1, running=0.
  - Includes a stale end marker, a skipped test, and a start received while RUNNING.
- total_cycles increments every cycle while state is WAIT_START or RUNNING, saturating.
- Timeout: when total_cycles reaches TIMEOUT_CYCLES-1 and will increment: go to FAIL with err_code=2.
- Same-cycle priority:
  - An event that completes the final round wins over timeout; result is DONE.
  - Timeout wins over any other event that cycle.
  - An out-of-order event wins over timeout; err_code=1.
- DONE and FAIL are terminal until reset. Events are ignored there; counters and the table hold.
- lat_out for an unwritten entry reads 0. lat_sel out of range reads 0.

Test Plan:
- Defaults; drive AB00, AB01, AB10, AB11, AB20, AB21 for 3 rounds, 100 cycles apart, start→end gap 50 cycles -> done=1, fail=0, every lat_out=50, cur_round=3.
- Round 1: after AB00, drive AB11 -> fail=1, err_code=1, running=0 at cycle SYNC_STAGES+1 after the change. Further markers leave the state unchanged.
- Hold checkbits=0000 with TIMEOUT_CYCLES=1000 -> fail=1, err_code=2, total_cycles=999 at the transition; done remains 0.
- Drive AB00, then 1234, then AB00 again (non-marker between) -> second AB00 raises fail with err_code=1. Holding AB00 steady produces no repeat event.
- Assert wb_rst_i for 1 cycle while RUNNING test 1, round 2 -> all outputs and the table read 0; a full sequence afterwards reaches done=1.
- Place the final AB21 event on exactly the timeout cycle -> done=1, fail=0. Place a non-final expected event on the timeout cycle instead -> fail=1, err_code=2.
